// File: rtl/exp_pulse_gen_if.sv
// Bus bundle between a stimulus owner and the pulse generator.
//   master: drives trig/amp/baseline, observes the sample stream and status.
//   slave : the generator side (exp_pulse_gen).
// Signals:
//   trig        start request
//   amp         signed pulse amplitude, latched when a trigger is accepted
//   baseline    signed offset added to every output sample
//   data_out    signed, saturated sample stream
//   busy        high from trigger acceptance through the end of holdoff
//   pulse_done  one-cycle strobe when the decay phase finishes
//   dropped_cnt saturating count of triggers ignored while busy
interface exp_pulse_gen_if #(
  parameter int unsigned SIZE_DATA = 16
) ();
  logic                        trig;
  logic signed [SIZE_DATA-1:0] amp;
  logic signed [SIZE_DATA-1:0] baseline;
  logic signed [SIZE_DATA-1:0] data_out;
  logic                        busy;
  logic                        pulse_done;
  logic [7:0]                  dropped_cnt;

  modport master (
    output trig, amp, baseline,
    input  data_out, busy, pulse_done, dropped_cnt
  );

  modport slave (
    input  trig, amp, baseline,
    output data_out, busy, pulse_done, dropped_cnt
  );
endinterface

// File: rtl/exp_pulse_gen.sv
// Detector-like pulse synthesizer: linear rise over 2^RISE_SHIFT cycles to the
// latched amplitude, then exponential decay (acc -= acc >>> DECAY_SHIFT) until
// the decrement vanishes, then HOLDOFF_LEN idle cycles before re-arming.
// Output is sat(baseline + acc [+ noise]), registered, one cycle behind acc.
// Ports:
//   clk     clock
//   reset   asynchronous, active-low reset (aborts any pulse in flight)
//   gen_if  exp_pulse_gen_if.slave bundle (trig/amp/baseline in; data_out,
//           busy, pulse_done, dropped_cnt out; all outputs registered)
// Build option: define EXP_PULSE_GEN_NOISE_EN to add a 16-bit Fibonacci LFSR
// (taps 16,14,13,11, seed 16'hACE1) whose low NOISE_BITS, read as signed, are
// added into the output sum. Without it the noise term is constant zero.
module exp_pulse_gen #(
  parameter int unsigned SIZE_DATA   = 16,
  parameter int unsigned RISE_SHIFT  = 2,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned HOLDOFF_LEN = 4,
  parameter int unsigned NOISE_BITS  = 4
) (
  input logic            clk,
  input logic            reset,
  exp_pulse_gen_if.slave gen_if
);

  localparam int unsigned AccW    = SIZE_DATA + 1;
  localparam int unsigned SumW    = SIZE_DATA + 2;
  localparam int unsigned RiseLen = 1 << RISE_SHIFT;
  localparam int unsigned CntMax  = (RiseLen > HOLDOFF_LEN) ? RiseLen : HOLDOFF_LEN;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {StIdle, StRise, StDecay, StHoldoff} state_e;

  state_e                      state_q, state_d;
  logic signed [AccW-1:0]      acc_q, acc_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic signed [SIZE_DATA-1:0] amp_q, amp_d;
  logic                        busy_q, busy_d;
  logic                        pulse_done_q, pulse_done_d;
  logic [7:0]                  dropped_q, dropped_d;
  logic signed [SIZE_DATA-1:0] data_out_q, data_out_d;

  logic signed [AccW-1:0]       step;
  logic signed [AccW-1:0]       decay;
  logic signed [NOISE_BITS-1:0] noise;
  logic signed [SumW-1:0]       sum;
  logic                         sum_fits;

`ifdef EXP_PULSE_GEN_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting form of x^16 + x^14 + x^13 + x^11 + 1.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign noise = $signed(lfsr_q[NOISE_BITS-1:0]);
`else
  assign noise = '0;
`endif

  assign step  = AccW'(amp_q >>> RISE_SHIFT);
  assign decay = acc_q >>> DECAY_SHIFT;

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    amp_d        = amp_q;
    busy_d       = busy_q;
    pulse_done_d = 1'b0;
    dropped_d    = dropped_q;

    if (gen_if.trig && (state_q != StIdle) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        if (gen_if.trig) begin
          amp_d   = gen_if.amp;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRise;
        end
      end
      StRise: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(RiseLen - 1)) begin
          // Land exactly on the amplitude, dropping the ramp truncation error.
          acc_d   = AccW'(amp_q);
          cnt_d   = '0;
          state_d = StDecay;
        end else begin
          acc_d = acc_q + step;
        end
      end
      StDecay: begin
        // Decrement of 0 (positive tail) or -1 (negative tail) means stalled.
        if ((decay == '0) || (decay == '1)) begin
          acc_d        = '0;
          pulse_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = StHoldoff;
        end else begin
          acc_d = acc_q - decay;
        end
      end
      StHoldoff: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(HOLDOFF_LEN - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating output sum; in range when the top three bits agree.
  always_comb begin
    sum        = SumW'(gen_if.baseline) + SumW'(acc_q) + SumW'(noise);
    sum_fits   = (sum[SumW-1:SIZE_DATA-1] == '0) || (sum[SumW-1:SIZE_DATA-1] == '1);
    data_out_d = sum[SIZE_DATA-1:0];
    if (!sum_fits) begin
      data_out_d = sum[SumW-1] ? {1'b1, {(SIZE_DATA-1){1'b0}}}
                               : {1'b0, {(SIZE_DATA-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      amp_q        <= '0;
      busy_q       <= 1'b0;
      pulse_done_q <= 1'b0;
      dropped_q    <= 8'd0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      amp_q        <= amp_d;
      busy_q       <= busy_d;
      pulse_done_q <= pulse_done_d;
      dropped_q    <= dropped_d;
      data_out_q   <= data_out_d;
    end
  end

  assign gen_if.data_out    = data_out_q;
  assign gen_if.busy        = busy_q;
  assign gen_if.pulse_done  = pulse_done_q;
  assign gen_if.dropped_cnt = dropped_q;

endmodule

// File: tb/tb_exp_pulse_gen.sv
// Directed bench for exp_pulse_gen with default parameters
// (SIZE_DATA=16, RISE_SHIFT=2, DECAY_SHIFT=3, HOLDOFF_LEN=4, NOISE_BITS=4).
module tb_exp_pulse_gen;
  localparam int unsigned SizeData  = 16;
  localparam int unsigned NoiseBits = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  int obs_q[$];
  int nz_q[$];

  exp_pulse_gen_if #(.SIZE_DATA(SizeData)) gen_if ();

  exp_pulse_gen #(
    .SIZE_DATA  (SizeData),
    .RISE_SHIFT (2),
    .DECAY_SHIFT(3),
    .HOLDOFF_LEN(4),
    .NOISE_BITS (NoiseBits)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .gen_if(gen_if)
  );

  always #5 clk = ~clk;

`ifdef EXP_PULSE_GEN_NOISE_EN
  // Reference LFSR; ref_prev is the value the DUT used for the current sample.
  logic [15:0] ref_lfsr;
  logic [15:0] ref_prev;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_lfsr <= 16'hACE1;
      ref_prev <= 16'h0000;
    end else begin
      ref_prev <= ref_lfsr;
      ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
    end
  end
`endif

  function automatic int noise_now();
`ifdef EXP_PULSE_GEN_NOISE_EN
    logic signed [NoiseBits-1:0] n;
    n = ref_prev[NoiseBits-1:0];
    return int'(n);
`else
    return 0;
`endif
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full pulse from IDLE, checked sample-by-sample against a decay model.
  task automatic run_pulse(input int base, input int a, input string tag);
    int accs[$];
    int acc;
    int n;
    accs = {};
    gen_if.baseline = SizeData'(base);
    gen_if.amp      = SizeData'(a);
    gen_if.trig     = 1'b1;
    tick();
    gen_if.trig = 1'b0;
    chk({tag, "_busy_start"}, gen_if.busy, 1);
    acc = a >>> 2;
    accs.push_back(0);
    accs.push_back(acc);
    accs.push_back(2 * acc);
    accs.push_back(3 * acc);
    accs.push_back(a);
    acc = a;
    while (((acc >>> 3) != 0) && ((acc >>> 3) != -1)) begin
      acc = acc - (acc >>> 3);
      accs.push_back(acc);
    end
    accs.push_back(0);
    n = accs.size();
    obs_q = {};
    nz_q  = {};
    for (int j = 0; j < n; j++) begin
      tick();
      obs_q.push_back(int'(gen_if.data_out));
      nz_q.push_back(noise_now());
      chk({tag, "_data"}, gen_if.data_out, clamp16(base + accs[j] + noise_now()));
      chk({tag, "_pulse_done"}, gen_if.pulse_done, (j == n - 2));
    end
    chk({tag, "_busy_hold"}, gen_if.busy, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk({tag, "_busy_tail"}, gen_if.busy, (k < 3));
    end
  endtask

  initial begin
    int head_p[9];
    int head_n[8];
    int pulses;
    int v;
    head_p = '{0, 200, 400, 600, 800, 700, 613, 537, 470};
    head_n = '{0, -200, -400, -600, -800, -700, -612, -535};

    // Reset state, then baseline-only output.
    reset           = 1'b0;
    gen_if.trig     = 1'b0;
    gen_if.amp      = '0;
    gen_if.baseline = 16'sd100;
    #12;
    chk("rst_data", gen_if.data_out, 0);
    chk("rst_busy", gen_if.busy, 0);
    chk("rst_pulse_done", gen_if.pulse_done, 0);
    chk("rst_dropped", gen_if.dropped_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("base_data", gen_if.data_out, clamp16(100 + noise_now()));
      chk("base_busy", gen_if.busy, 0);
    end

    // Positive pulse.
    run_pulse(0, 800, "pos");
    for (int i = 0; i < 9; i++) chk("pos_head", obs_q[i] - nz_q[i], head_p[i]);
    v = obs_q.size();
    chk("pos_last_nonzero", obs_q[v-2] - nz_q[v-2], 7);
    chk("pos_final_zero", obs_q[v-1] - nz_q[v-1], 0);
    chk("pos_dropped", gen_if.dropped_cnt, 0);

    // Negative pulse.
    run_pulse(0, -800, "neg");
    for (int i = 0; i < 8; i++) chk("neg_head", obs_q[i] - nz_q[i], head_n[i]);
    v = obs_q.size();
    chk("neg_tail_range", ((obs_q[v-2] - nz_q[v-2]) >= -8) && ((obs_q[v-2] - nz_q[v-2]) <= -1), 1);
    chk("neg_final_zero", obs_q[v-1] - nz_q[v-1], 0);

    // Saturation both ways.
    run_pulse(32700, 800, "sat_hi");
    chk("sat_hi_peak", obs_q[4], 32767);
    run_pulse(-32700, -800, "sat_lo");
    chk("sat_lo_peak", obs_q[4], -32768);

    // Zero amplitude still runs the sequence.
    run_pulse(0, 0, "zero_amp");

    // Trigger held 3 cycles, then pulsed on the last holdoff cycle.
    gen_if.amp      = 16'sd0;
    gen_if.baseline = 16'sd0;
    pulses = 0;
    for (int n = 0; n < 14; n++) begin
      gen_if.trig = (n < 3) || (n == 9);
      tick();
      if (gen_if.pulse_done) pulses++;
      if (n == 8) chk("trig_busy_last_holdoff", gen_if.busy, 1);
      if (n == 9) chk("trig_busy_released", gen_if.busy, 0);
    end
    gen_if.trig = 1'b0;
    chk("trig_one_pulse", pulses, 1);
    chk("trig_dropped3", gen_if.dropped_cnt, 3);
    chk("trig_idle", gen_if.busy, 0);

    // Many ignored triggers saturate the counter.
    gen_if.trig = 1'b1;
    for (int i = 0; i < 400; i++) tick();
    gen_if.trig = 1'b0;
    chk("dropped_sat", gen_if.dropped_cnt, 255);
    begin
      int budget;
      budget = 0;
      while (gen_if.busy && budget < 40) begin
        tick();
        budget++;
      end
      chk("drain_idle", gen_if.busy, 0);
    end

    // Reset in the middle of decay.
    gen_if.amp  = 16'sd800;
    gen_if.trig = 1'b1;
    tick();
    gen_if.trig = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy_before", gen_if.busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_data", gen_if.data_out, 0);
    chk("mid_rst_busy", gen_if.busy, 0);
    chk("mid_rst_pulse_done", gen_if.pulse_done, 0);
    chk("mid_rst_dropped", gen_if.dropped_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    run_pulse(0, 800, "post_rst");
    chk("post_rst_ramp1", obs_q[1] - nz_q[1], 200);
    chk("post_rst_peak", obs_q[4] - nz_q[4], 800);

`ifdef EXP_PULSE_GEN_NOISE_EN
    gen_if.amp      = 16'sd0;
    gen_if.baseline = 16'sd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("noise_range", (gen_if.data_out >= -8) && (gen_if.data_out <= 7), 1);
      chk("noise_seq", gen_if.data_out, noise_now());
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exp_pulse_gen.md
Name: exp_pulse_gen

Overview:
Synthesizes detector-like pulses (linear rise, exponential decay) as signed samples. It is the stimulus source for the trapezoidal shaping filter chain and drives the filter's signed input_data port directly. A trigger plus amplitude starts one pulse. The output is baseline plus the pulse, saturated. Used for in-system self-test and for bench stimulus of the shaper.

Parameters:
SIZE_DATA, 16, width of amplitude, baseline and output samples (signed).
RISE_SHIFT, 2, rise lasts 2^RISE_SHIFT cycles; ramp step = amp >>> RISE_SHIFT.
DECAY_SHIFT, 3, per-cycle decay: acc <= acc - (acc >>> DECAY_SHIFT), i.e. time constant ~2^DECAY_SHIFT cycles.
HOLDOFF_LEN, 4, idle cycles after decay ends before a new trigger is accepted (>=1).
NOISE_BITS, 4, noise width when the optional feature is compiled in (1..15).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
trig  in  1  start request, sampled on rising clk
amp  in  SIZE_DATA  signed pulse amplitude, latched when a trigger is accepted
baseline  in  SIZE_DATA  signed offset, sampled every cycle
data_out  out  SIZE_DATA  signed sample stream to the filter
busy  out  1  high from trigger acceptance through the end of HOLDOFF
pulse_done  out  1  one-cycle strobe on DECAY->HOLDOFF
dropped_cnt  out  8  saturating count of triggers ignored while busy

Behaviour:
- Reset (async, low): state=IDLE, acc=0, cnt=0, amp_q=0, data_out=0, busy=0, pulse_done=0, dropped_cnt=0. Reset mid-pulse aborts the pulse; there is no resume.
- Internal accumulator acc is SIZE_DATA+1 bits signed; step = amp_q >>> RISE_SHIFT (arithmetic shift).
- IDLE: if trig=1, then amp_q<=amp, acc<=0, cnt<=0, busy<=1, go RISE. Otherwise acc stays 0.
- RISE: acc<=acc+step, cnt++. When cnt==2^RISE_SHIFT-1, acc<=amp_q exactly (removes truncation error) and go DECAY. RISE lasts exactly 2^RISE_SHIFT cycles.
- DECAY: if (acc >>> DECAY_SHIFT) is 0 or -1, then acc<=0, pulse_done<=1 for one cycle, cnt<=0, go HOLDOFF. Otherwise acc<=acc-(acc>>>DECAY_SHIFT).
- HOLDOFF: cnt++. When cnt==HOLDOFF_LEN-1, busy<=0 and go IDLE.
- amp=0: the pulse still runs its full sequence. In that case DECAY terminates on its first cycle.
- Negative amp gives a negative-polarity pulse, with the same rules.
- Trigger while state != IDLE (including the final HOLDOFF cycle): ignored, and dropped_cnt++ saturating at 255.
- Output register: data_out <= sat(baseline + acc [+ noise]), computed at SIZE_DATA+2 bits and clamped to [-2^(SIZE_DATA-1), 2^(SIZE_DATA-1)-1].
- data_out lags acc by one cycle. Latency: trig sampled at edge T gives the first ramp sample on data_out after edge T+2.
- No combinational path from any input to any output.

Optional Feature:
EXP_PULSE_GEN_NOISE_EN defined:
- A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle, including in IDLE.
- noise = low NOISE_BITS of the LFSR, read as signed and sign-extended.
- noise is added into the saturating output sum.

Not defined:
- No LFSR is instantiated, and data_out = sat(baseline + acc).

Test Plan:
- Reset, baseline=100, no trig -> data_out=100 constant, busy=0, dropped_cnt=0.
- RISE_SHIFT=2, DECAY_SHIFT=3, baseline=0, amp=800, single trig -> data_out 200,400,600,800, then 700,613,537,470,... down to <8. The next sample is 0 and pulse_done pulses once. busy drops HOLDOFF_LEN cycles after pulse_done.
- amp=-800 -> mirror sequence -200,-400,-600,-800,-700,... ending at 0. Check the final steps around -8..-1 terminate correctly.
- baseline=32700, amp=800 -> data_out clamps at 32767 with no wrap. baseline=-32700, amp=-800 -> clamps at -32768.
- trig held high for 3 cycles, then pulsed in the last HOLDOFF cycle -> exactly one pulse and dropped_cnt=3. 300 ignored triggers -> dropped_cnt=255.
- Reset asserted mid-DECAY -> all outputs 0 immediately. After release, a new trig produces a clean pulse from 0. With EXP_PULSE_GEN_NOISE_EN and amp=0, baseline=0 -> data_out stays within [-8,7] and matches the reference LFSR sequence.
